spi_master_ctrl: RTL and testbench

//  System-clock SPI master that drives the SCLK/MOSI/CS pins of the SPI slave execution unit.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_half_period_cnt.sv | 41 ++++
 rtl/spi_master_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and constants for the SPI master blocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    // Default frame length; must match the slave execution unit.
    localparam int SPI_BITS_DEFAULT = 5;

    // Master sequencing states. IDLE is the only state with chip select high.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } spi_mst_state_t;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int spi_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : spi_pkg

`default_nettype wire

// File: rtl/spi_half_period_cnt.sv
// ============================================================================
//  Module   : spi_half_period_cnt
//  Purpose  : Free-running 0..CLK_DIV-1 counter with synchronous clear and a
//             terminal-count flag marking the last cycle of a half-period.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_half_period_cnt
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam int              CW   = spi_cnt_width(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count through one half-period, wrapping to zero after the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Terminal count is suppressed while held in clear so idle never advances.
    assign tc = ~clear & (cnt == LAST);

endmodule : spi_half_period_cnt

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ============================================================================
//  Module   : spi_master_ctrl
//  Purpose  : Mode-0 SPI master. Accepts one word over valid/ready, shifts it
//             out MSB first on MOSI, captures the same number of MISO bits and
//             pulses done with the received word. All pins come from flops.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int BITS    = SPI_BITS_DEFAULT,
    parameter int CLK_DIV = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [BITS-1:0] o_data,
    output logic            o_done,
    output logic            o_busy,
    output logic            o_sclk,
    output logic            o_mosi,
    input  logic            i_miso,
    output logic            o_cs
);

    localparam int            BW        = $clog2(BITS + 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(BITS - 1);

    spi_mst_state_t  state;
    spi_mst_state_t  state_nxt;
    logic [BITS-1:0] tx_reg;
    logic [BITS-1:0] tx_nxt;
    logic [BITS-1:0] rx_reg;
    logic [BITS-1:0] rx_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   bit_cnt_nxt;
    logic            done_nxt;
    logic            half_tc;
    logic            accept;

    assign o_ready = (state == IDLE);
    assign accept  = i_valid & o_ready;

    // Every non-idle state lasts one full half-period; idle holds it cleared.
    spi_half_period_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_half_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (state == IDLE),
        .tc    (half_tc)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and shift-register updates; transitions happen on half-period ends.
    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx_reg;
        rx_nxt      = rx_reg;
        bit_cnt_nxt = bit_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = SETUP;
                    tx_nxt      = i_data;
                    rx_nxt      = '0;
                    bit_cnt_nxt = '0;
                end
            end
            SETUP: begin
                if (half_tc) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (half_tc) begin
                    // MISO was updated on the previous falling edge, so it is
                    // settled at the end of the high phase.
                    rx_nxt      = {rx_reg[BITS-2:0], i_miso};
                    bit_cnt_nxt = bit_cnt + BW'(1);
                    if (bit_cnt == BITS_LAST) begin
                        state_nxt = HOLD;
                    end else begin
                        // Shift on entry to LOW so MOSI changes on the falling edge.
                        state_nxt = LOW;
                        tx_nxt    = tx_reg << 1;
                    end
                end
            end
            LOW: begin
                if (half_tc) begin
                    state_nxt = HIGH;
                end
            end
            HOLD: begin
                if (half_tc) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_reg  <= '0;
            rx_reg  <= '0;
            bit_cnt <= '0;
        end else begin
            tx_reg  <= tx_nxt;
            rx_reg  <= rx_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Pins and status are decoded from the next state so they line up with
    // the state register while still coming straight out of flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cs   <= 1'b1;
            o_sclk <= 1'b0;
            o_mosi <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_cs   <= (state_nxt == IDLE);
            o_sclk <= (state_nxt == HIGH);
            o_mosi <= (state_nxt == IDLE) ? 1'b0 : tx_nxt[BITS-1];
            o_busy <= (state_nxt != IDLE);
            o_done <= done_nxt;
        end
    end

    // Received word is published with done and held until the next frame ends.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
        end else if (done_nxt) begin
            o_data <= rx_reg;
        end
    end

endmodule : spi_master_ctrl

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
//  Module   : tb_spi_master_ctrl
//  Purpose  : Self-checking bench for spi_master_ctrl (CLK_DIV=4 and 1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int BITS = SPI_BITS_DEFAULT;
    localparam int DIV0 = 4;
    localparam int DIV1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    // ---------------- DUT 0 (CLK_DIV=4) ----------------
    logic [BITS-1:0] data0 = '0;
    logic [BITS-1:0] odata0;
    logic valid0 = 1'b0;
    logic ready0, done0, busy0, sclk0, mosi0, miso0, cs0;
    logic loop0 = 1'b1;
    logic [BITS-1:0] slave_word = '0;
    logic [BITS-1:0] sreg = '0;

    assign miso0 = loop0 ? mosi0 : sreg[BITS-1];

    spi_master_ctrl #(.BITS(BITS), .CLK_DIV(DIV0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_data(data0), .i_valid(valid0),
        .o_ready(ready0), .o_data(odata0), .o_done(done0), .o_busy(busy0),
        .o_sclk(sclk0), .o_mosi(mosi0), .i_miso(miso0), .o_cs(cs0)
    );

    // ---------------- DUT 1 (CLK_DIV=1, loopback) ----------------
    logic [BITS-1:0] data1 = '0;
    logic [BITS-1:0] odata1;
    logic valid1 = 1'b0;
    logic ready1, done1, busy1, sclk1, mosi1, cs1;

    spi_master_ctrl #(.BITS(BITS), .CLK_DIV(DIV1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
        .o_ready(ready1), .o_data(odata1), .o_done(done1), .o_busy(busy1),
        .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(mosi1), .o_cs(cs1)
    );

    // Pin monitors and slave model, sampled on the falling system clock edge.
    bit          mosi_hist0[$];
    int          rise0 = 0, cs_low0 = 0, done_cnt0 = 0;
    logic        psclk0 = 1'b0, pcs0 = 1'b1;
    int unsigned rise_cyc1[$];
    int          rise1 = 0, cs_low1 = 0;
    logic        psclk1 = 1'b0;

    always @(negedge clk) begin
        if (sclk0 && !psclk0) begin
            mosi_hist0.push_back(mosi0);
            rise0 = rise0 + 1;
        end
        if (!cs0) cs_low0 = cs_low0 + 1;
        if (done0) done_cnt0 = done_cnt0 + 1;
        // Slave: present MSB when selected, advance on each falling SCLK.
        if (!cs0 && pcs0) sreg = slave_word;
        else if (!sclk0 && psclk0) sreg = sreg << 1;
        psclk0 = sclk0;
        pcs0   = cs0;
        if (sclk1 && !psclk1) begin
            rise_cyc1.push_back(cyc);
            rise1 = rise1 + 1;
        end
        if (!cs1) cs_low1 = cs_low1 + 1;
        psclk1 = sclk1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input string tag);
        int n = 0;
        while (!done0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done0}, 32'd1);
    endtask

    // One frame on DUT 0 with expectations from the frame rules:
    // MOSI = word MSB first, RX = loopback word or slave word,
    // CS low for CLK_DIV*(2*BITS+1) cycles, BITS rising edges.
    task automatic run0(input logic [BITS-1:0] d, input bit lp,
                        input logic [BITS-1:0] sw, input int inject_at, input string tag);
        logic [BITS-1:0] exp_rx = lp ? d : sw;
        logic [BITS-1:0] got_mosi;
        int h = mosi_hist0.size();
        int c = cs_low0;
        int r = rise0;
        int dc = done_cnt0;
        loop0 = lp;
        slave_word = sw;
        check({tag, "_ready_idle"}, {31'd0, ready0}, 32'd1);
        data0 = d;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        check({tag, "_busy"}, {31'd0, busy0}, 32'd1);
        check({tag, "_cs_low"}, {31'd0, cs0}, 32'd0);
        data0 = BITS'($urandom);
        if (inject_at > 0) begin
            repeat (inject_at - 1) tick();
            valid0 = 1'b1;
            data0 = 5'b00001;
            check({tag, "_ready_mid"}, {31'd0, ready0}, 32'd0);
            tick();
            valid0 = 1'b0;
        end
        wait_done0(tag);
        check({tag, "_rx"}, 32'(odata0), 32'(exp_rx));
        check({tag, "_rises"}, 32'(rise0 - r), 32'(BITS));
        check({tag, "_cs_len"}, 32'(cs_low0 - c), 32'(DIV0 * (2 * BITS + 1)));
        got_mosi = '0;
        for (int i = 0; i < BITS; i++) begin
            if (h + i < mosi_hist0.size()) got_mosi[BITS-1-i] = mosi_hist0[h + i];
        end
        check({tag, "_mosi"}, 32'(got_mosi), 32'(d));
        check({tag, "_ready_done"}, {31'd0, ready0}, 32'd1);
        tick();
        check({tag, "_done_1cyc"}, {31'd0, done0}, 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt0 - dc), 32'd1);
        check({tag, "_data_held"}, 32'(odata0), 32'(exp_rx));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [BITS-1:0] d, sw, prev;
        int c, r, n;
        bit lp;

        // Reset values
        repeat (3) tick();
        check("rst_cs", {31'd0, cs0}, 32'd1);
        check("rst_sclk", {31'd0, sclk0}, 32'd0);
        check("rst_mosi", {31'd0, mosi0}, 32'd0);
        check("rst_data", 32'(odata0), 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_ready", {31'd0, ready0}, 32'd1);
        check("rst_ready1", {31'd0, ready1}, 32'd1);
        rst = 1'b0;
        repeat (2) tick();

        // Directed frames
        run0(5'b10110, 1'b1, 5'b00000, 0, "loop");
        run0(5'b01001, 1'b0, 5'b11111, 0, "miso1");
        run0(5'b10101, 1'b0, 5'b00000, 0, "miso0");
        run0(5'b10110, 1'b1, 5'b00000, 10, "ignore");

        // Back-to-back with valid held high
        loop0 = 1'b1;
        data0 = 5'b00011;
        valid0 = 1'b1;
        tick();
        data0 = 5'b11100;
        wait_done0("b2b1");
        check("b2b1_rx", 32'(odata0), 32'(5'b00011));
        check("b2b1_cs_gap", {31'd0, cs0}, 32'd1);
        check("b2b1_ready", {31'd0, ready0}, 32'd1);
        tick();
        valid0 = 1'b0;
        check("b2b_cs_relow", {31'd0, cs0}, 32'd0);
        check("b2b_busy", {31'd0, busy0}, 32'd1);
        wait_done0("b2b2");
        check("b2b2_rx", 32'(odata0), 32'(5'b11100));
        tick();

        // Reset mid-frame
        loop0 = 1'b1;
        c = done_cnt0;
        data0 = 5'b11011;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        repeat (19) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_cs", {31'd0, cs0}, 32'd1);
        check("abort_sclk", {31'd0, sclk0}, 32'd0);
        check("abort_mosi", {31'd0, mosi0}, 32'd0);
        check("abort_data", 32'(odata0), 32'd0);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_ready", {31'd0, ready0}, 32'd1);
        repeat (3) tick();
        rst = 1'b0;
        repeat (60) tick();
        check("abort_no_done", 32'(done_cnt0 - c), 32'd0);
        run0(5'b01101, 1'b1, 5'b00000, 0, "post_rst");

        // Randomised frames against the reference model
        for (int k = 0; k < 8; k++) begin
            d  = BITS'($urandom);
            sw = BITS'($urandom);
            lp = 1'($urandom_range(0, 1));
            run0(d, lp, sw, 0, $sformatf("rnd%0d", k));
        end

        // CLK_DIV=1 instance, loopback
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 5'b10110 : BITS'($urandom);
            c = cs_low1;
            r = rise1;
            n = rise_cyc1.size();
            data1 = d;
            valid1 = 1'b1;
            tick();
            valid1 = 1'b0;
            prev = '0;
            begin
                int w = 0;
                while (!done1 && w < 100) begin
                    tick();
                    w++;
                end
            end
            check($sformatf("div1_%0d_done", k), {31'd0, done1}, 32'd1);
            check($sformatf("div1_%0d_rx", k), 32'(odata1), 32'(d));
            check($sformatf("div1_%0d_cs_len", k), 32'(cs_low1 - c), 32'(DIV1 * (2 * BITS + 1)));
            check($sformatf("div1_%0d_rises", k), 32'(rise1 - r), 32'(BITS));
            for (int i = 1; i < BITS; i++) begin
                if (n + i < rise_cyc1.size())
                    check($sformatf("div1_%0d_period%0d", k, i),
                          rise_cyc1[n + i] - rise_cyc1[n + i - 1], 32'd2);
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_spi_master_ctrl

`default_nettype wire
